// File: rtl/esp32_spi_btn_slave_if.sv
// ESP32 SPI pin bundle between the ESP32 (master) and the button slave.
// The slave drives MISO and its output enable; the top level owns the tristate.
`timescale 1ns/1ps

interface esp32_spi_btn_slave_if;
    logic spi_csn;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_csn,
        output spi_clk,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_csn,
        input  spi_clk,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/esp32_spi_btn_slave.sv
// Oversampled SPI mode-0 slave: shifts button state out on MISO and strobes each received byte.
// Optional button debounce is enabled with the ESP32_SPI_BTN_DEBOUNCE_EN macro.
`timescale 1ns/1ps

module esp32_spi_btn_slave #(
    parameter int C_btn_width     = 7,
    parameter int C_debounce_bits = 16
) (
    input  logic                   clk_25mhz,
    input  logic                   rstn,
    esp32_spi_btn_slave_if.slave   spi,
    input  logic [C_btn_width-1:0] btn,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   rx_first,
    output logic                   frame_err,
    output logic [C_btn_width-1:0] btn_state
);

    if (C_btn_width < 1 || C_btn_width > 8 || C_debounce_bits < 1) begin : g_param_check
        $error("esp32_spi_btn_slave: C_btn_width must be 1..8 and C_debounce_bits >= 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [C_btn_width-1:0] btn_s1_q;
    logic [C_btn_width-1:0] btn_s2_q;
    logic [C_btn_width-1:0] btn_state_w;

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

`ifdef ESP32_SPI_BTN_DEBOUNCE_EN
    localparam logic [C_debounce_bits-1:0] DB_MAX = '1;

    logic [C_debounce_bits-1:0] db_cnt_q [C_btn_width];
    logic [C_debounce_bits-1:0] db_cnt_d [C_btn_width];
    logic [C_btn_width-1:0]     db_state_q;
    logic [C_btn_width-1:0]     db_state_d;

    // A bit only flips after its synced input has disagreed with it for a full window.
    always_comb begin
        db_state_d = db_state_q;
        for (int i = 0; i < C_btn_width; i++) begin
            db_cnt_d[i] = '0;
            if (btn_s2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    db_state_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + C_debounce_bits'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            db_state_q <= '0;
            // NOTE: the counter array is small and must start from zero, so it is reset element by element.
            for (int i = 0; i < C_btn_width; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_state_q <= db_state_d;
            for (int i = 0; i < C_btn_width; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign btn_state_w = db_state_q;
`else
    assign btn_state_w = btn_s2_q;
`endif

    assign btn_state = btn_state_w;

    // ------------------------------------------------------------------
    // SPI pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [2:0] csn_sync_q,  csn_sync_d;
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic       csn_fall, csn_rise, sclk_rise, sclk_fall, mosi_bit;

    assign csn_fall  = ~csn_sync_q[1] &  csn_sync_q[2];
    assign csn_rise  =  csn_sync_q[1] & ~csn_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign mosi_bit  =  mosi_sync_q[1];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_e     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] tx_sr_q,    tx_sr_d;
    logic [7:0] rx_sr_q,    rx_sr_d;
    logic       first_q,    first_d;
    logic       rx_done_q,  rx_done_d;
    logic       done_first_q, done_first_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       frame_err_q, frame_err_d;
    logic       miso_q,     miso_d;
    logic       miso_oe_q,  miso_oe_d;
    logic [7:0] tx_byte;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        tx_byte = '0;
        tx_byte[C_btn_width-1:0] = btn_state_w;

        csn_sync_d   = {csn_sync_q[1:0],  spi.spi_csn};
        sclk_sync_d  = {sclk_sync_q[1:0], spi.spi_clk};
        mosi_sync_d  = {mosi_sync_q[0],   spi.spi_mosi};

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        first_d      = first_q;
        rx_done_d    = 1'b0;
        done_first_d = done_first_q;
        frame_err_d  = 1'b0;
        miso_d       = 1'b0;
        miso_oe_d    = 1'b0;

        // Completed byte is presented one cycle after the shift register fills.
        rx_valid_d   = rx_done_q;
        rx_first_d   = rx_done_q & done_first_q;
        rx_data_d    = rx_done_q ? rx_sr_q : rx_data_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (csn_fall) begin
                    state_d   = ST_ACTIVE;
                    tx_sr_d   = tx_byte;
                    first_d   = 1'b1;
                    miso_oe_d = 1'b1;
                    miso_d    = tx_byte[7];
                end
            end
            ST_ACTIVE: begin
                miso_oe_d = 1'b1;
                miso_d    = tx_sr_q[7];
                if (csn_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    first_d     = 1'b0;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    miso_oe_d   = 1'b0;
                    miso_d      = 1'b0;
                end else if (sclk_rise) begin
                    rx_sr_d   = {rx_sr_q[6:0], mosi_bit};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_done_d    = 1'b1;
                        done_first_d = first_q;
                        first_d      = 1'b0;
                    end
                end else if (sclk_fall) begin
                    // Byte boundary reloads live button state so every byte is fresh.
                    tx_sr_d = (bit_cnt_q == 3'd0) ? tx_byte : {tx_sr_q[6:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            csn_sync_q   <= 3'b111;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            first_q      <= 1'b0;
            rx_done_q    <= 1'b0;
            done_first_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
        end else begin
            csn_sync_q   <= csn_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            first_q      <= first_d;
            rx_done_q    <= rx_done_d;
            done_first_q <= done_first_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            frame_err_q  <= frame_err_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = miso_oe_q;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign rx_first        = rx_first_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_esp32_spi_btn_slave.sv
// Scoreboard bench for esp32_spi_btn_slave: a mode-0 master pushes expected bytes,
// a negedge monitor pops and compares whenever the DUT strobes or the master completes a byte.
`timescale 1ns/1ps

module tb_esp32_spi_btn_slave;

    localparam int BW = 7;
    localparam int DB = 4;
`ifdef ESP32_SPI_BTN_DEBOUNCE_EN
    localparam int BTN_LAT = 2 + 2**DB;
`else
    localparam int BTN_LAT = 2;
`endif

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [BW-1:0] btn  = '0;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_first, frame_err;
    logic [BW-1:0] btn_state;

    esp32_spi_btn_slave_if spi_if ();

    esp32_spi_btn_slave #(
        .C_btn_width     (BW),
        .C_debounce_bits (DB)
    ) dut (
        .clk_25mhz (clk),
        .rstn      (rstn),
        .spi       (spi_if),
        .btn       (btn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .frame_err (frame_err),
        .btn_state (btn_state)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } rx_exp_t;

    rx_exp_t    rx_exp_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] miso_obs_q[$];
    int         err_exp = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise.
    task automatic spi_bits(input logic [7:0] mosi_byte, input int nbits,
                            input logic [BW-1:0] btn_next, input int btn_bit,
                            output logic [7:0] miso_byte);
        miso_byte = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_if.spi_mosi = mosi_byte[i];
            wait_cyc(5);
            miso_byte[i] = spi_if.spi_miso;
            spi_if.spi_clk = 1'b1;
            if (i == btn_bit) btn = btn_next;
            wait_cyc(4);
            spi_if.spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] mosi_byte, input logic first,
                             input logic [7:0] miso_exp,
                             input logic [BW-1:0] btn_next, input int btn_bit);
        logic [7:0] got;
        rx_exp_q.push_back('{data: mosi_byte, first: first});
        miso_exp_q.push_back(miso_exp);
        spi_bits(mosi_byte, 8, btn_next, btn_bit, got);
        miso_obs_q.push_back(got);
    endtask

    task automatic frame_end();
        wait_cyc(2);
        spi_if.spi_csn = 1'b1;
    endtask

    // Monitor: consumes expectations whenever the DUT or master presents a result.
    rx_exp_t e_mon;
    logic    rx_valid_prev  = 1'b0;
    logic    frame_err_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid) begin
                check("rx_valid_single_cycle", rx_valid_prev, 1'b0);
                if (rx_exp_q.size() == 0) begin
                    check("rx_valid_unexpected", rx_valid, 1'b0);
                end else begin
                    e_mon = rx_exp_q.pop_front();
                    check("rx_data", rx_data, e_mon.data);
                    check("rx_first", rx_first, e_mon.first);
                end
            end
            if (frame_err) begin
                check("frame_err_single_cycle", frame_err_prev, 1'b0);
                if (err_exp == 0) check("frame_err_unexpected", frame_err, 1'b0);
                else err_exp--;
            end
            if (miso_obs_q.size() > 0) begin
                check("miso_expected_available", miso_exp_q.size() > 0, 1'b1);
                if (miso_exp_q.size() > 0)
                    check("miso_byte", miso_obs_q.pop_front(), miso_exp_q.pop_front());
                else
                    void'(miso_obs_q.pop_front());
            end
        end
        rx_valid_prev  <= rx_valid;
        frame_err_prev <= frame_err;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        logic [7:0] dummy;
`ifdef ESP32_SPI_BTN_DEBOUNCE_EN
        logic seen;
`endif
        spi_if.spi_csn  = 1'b1;
        spi_if.spi_clk  = 1'b0;
        spi_if.spi_mosi = 1'b0;
        btn = 7'h7F;

        // Reset values, with buttons pressed to show btn_state is held clear.
        repeat (3) @(negedge clk);
        check("reset_miso", spi_if.spi_miso, 1'b0);
        check("reset_miso_oe", spi_if.spi_miso_oe, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_first", rx_first, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_btn_state", btn_state, 7'h00);

        btn = '0;
        wait_cyc(1);
        rstn = 1'b1;
        wait_cyc(BTN_LAT + 5);

`ifdef ESP32_SPI_BTN_DEBOUNCE_EN
        // Short glitch never reaches btn_state.
        btn[0] = 1'b1;
        wait_cyc(5);
        btn[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            seen |= btn_state[0];
        end
        check("debounce_glitch_rejected", seen, 1'b0);
        // Held press appears after 2 sync cycles plus the full window.
        btn[0] = 1'b1;
        wait_cyc(2 + 2**DB - 1);
        check("debounce_not_yet", btn_state[0], 1'b0);
        wait_cyc(1);
        check("debounce_accepted", btn_state[0], 1'b1);
        btn = 7'h25;
        wait_cyc(BTN_LAT + 5);
`else
        // Two-cycle synchroniser latency.
        btn = 7'h25;
        wait_cyc(1);
        check("btn_lat_cycle1", btn_state, 7'h00);
        wait_cyc(1);
        check("btn_lat_cycle2", btn_state, 7'h25);
        wait_cyc(5);
`endif

        // Single byte: OE rises exactly 3 cycles after CSn falls.
        spi_if.spi_csn = 1'b0;
        wait_cyc(2);
        check("oe_before_csn_latency", spi_if.spi_miso_oe, 1'b0);
        wait_cyc(1);
        check("oe_after_csn_latency", spi_if.spi_miso_oe, 1'b1);
        send_byte(8'hA5, 1'b1, 8'h25, 7'h25, -1);
        frame_end();
        wait_cyc(2);
        check("oe_held_after_csn_rise", spi_if.spi_miso_oe, 1'b1);
        wait_cyc(1);
        check("oe_dropped_after_csn_rise", spi_if.spi_miso_oe, 1'b0);
        check("miso_idle_zero", spi_if.spi_miso, 1'b0);
        wait_cyc(10);

        // Two-byte frame with a button change during byte 1.
        spi_if.spi_csn = 1'b0;
        send_byte(8'h3C, 1'b1, 8'h25, 7'h01, 2);
        send_byte(8'h81, 1'b0, 8'h01, 7'h01, -1);
        frame_end();
        wait_cyc(10);

        // Aborted byte after 5 rises.
        spi_if.spi_csn = 1'b0;
        spi_bits(8'hFF, 5, 7'h01, -1, dummy);
        err_exp++;
        wait_cyc(2);
        spi_if.spi_csn = 1'b1;
        wait_cyc(3);
        check("abort_oe_off", spi_if.spi_miso_oe, 1'b0);
        wait_cyc(10);

        // Following frame decodes cleanly; second byte carries MSB-heavy buttons.
        spi_if.spi_csn = 1'b0;
        send_byte(8'h5A, 1'b1, 8'h01, 7'h7F, 2);
        send_byte(8'h66, 1'b0, 8'h7F, 7'h7F, -1);
        frame_end();
        wait_cyc(10);

        // Reset mid-frame after 3 bits.
        spi_if.spi_csn = 1'b0;
        spi_bits(8'hC3, 3, 7'h7F, -1, dummy);
        wait_cyc(1);
        rstn = 1'b0;
        @(negedge clk);
        check("midreset_miso", spi_if.spi_miso, 1'b0);
        check("midreset_miso_oe", spi_if.spi_miso_oe, 1'b0);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_btn_state", btn_state, 7'h00);
        spi_if.spi_csn = 1'b1;
        wait_cyc(3);
        rstn = 1'b1;
        wait_cyc(BTN_LAT + 5);

        // Recovery frame after reset.
        spi_if.spi_csn = 1'b0;
        send_byte(8'h99, 1'b1, 8'h7F, 7'h7F, -1);
        frame_end();
        wait_cyc(20);

        check("rx_queue_drained", rx_exp_q.size(), 0);
        check("miso_queue_drained", miso_exp_q.size(), 0);
        check("frame_err_drained", err_exp, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
